// File: rtl/pixel_frame_sink.sv
`default_nettype none
// =====================================================================
// Module   : pixel_frame_sink
// Purpose  : Terminal consumer of the processed pixel stream. Packs four
//            8-bit pixels into one 32-bit word, writes words to a frame
//            buffer over a held-request/ack port, and reports a per-frame
//            checksum, a frame-done pulse and a frame count.
// Revision : 1.0  initial release
// =====================================================================
module pixel_frame_sink #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [7:0]        pixel_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    input  logic              wr_ack,
    output logic              frame_done,
    output logic [15:0]       checksum,
    output logic [15:0]       frame_count
);
    localparam int c_npix   = IMG_W * IMG_H;
    localparam int c_nwords = c_npix / 4;
    localparam int c_pix_w  = (c_npix > 1) ? $clog2(c_npix) : 1;
    localparam logic [c_pix_w-1:0] c_last_pix  = c_pix_w'(c_npix - 1);
    localparam logic [ADDR_W-1:0]  c_last_word = ADDR_W'(c_nwords - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [1:0]          byte_cnt_q,    byte_cnt_d;
    logic [c_pix_w-1:0]  pix_cnt_q,     pix_cnt_d;
    logic [15:0]         acc_q,         acc_d;
    logic [15:0]         sum_q,         sum_d;        // finished frame sum awaiting its last write
    logic [23:0]         pack_q,        pack_d;       // byte lanes 0..2 of the word being built
    logic                out_full_q,    out_full_d;
    logic [31:0]         wr_data_q,     wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q,     wr_addr_d;
    logic                ready_q,       ready_d;
    logic                frame_done_q,  frame_done_d;
    logic [15:0]         checksum_q,    checksum_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic        w_accept;
    logic        w_load;
    logic        w_xfer;
    logic        w_last_pix;
    logic        w_last_word;
    logic [15:0] w_acc_sum;

    // Next-state logic: capture FSM, packing, write port and frame bookkeeping
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        acc_d         = acc_q;
        sum_d         = sum_q;
        pack_d        = pack_q;
        wr_data_d     = wr_data_q;
        wr_addr_d     = wr_addr_q;
        frame_done_d  = 1'b0;
        checksum_d    = checksum_q;
        frame_count_d = frame_count_q;

        w_accept    = valid_in && ready_q;
        w_load      = w_accept && (byte_cnt_q == 2'd3);
        w_xfer      = out_full_q && wr_ack;
        w_last_pix  = (pix_cnt_q == c_last_pix);
        w_last_word = (wr_addr_q == c_last_word);
        w_acc_sum   = acc_q + {8'd0, pixel_in};

        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (w_accept && w_last_pix && !enable) state_d = ST_DRAIN;
            ST_DRAIN: if (!out_full_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            pix_cnt_d  = w_last_pix ? '0 : pix_cnt_q + c_pix_w'(1);
            // The frame sum is set aside at the last pixel so that pixels of
            // the next frame accepted before the final write never mix in.
            if (w_last_pix) begin
                sum_d = w_acc_sum;
                acc_d = '0;
            end else begin
                acc_d = w_acc_sum;
            end
            case (byte_cnt_q)
                2'd0:    pack_d[7:0]   = pixel_in;
                2'd1:    pack_d[15:8]  = pixel_in;
                2'd2:    pack_d[23:16] = pixel_in;
                default: wr_data_d     = {pixel_in, pack_q};
            endcase
        end

        // A load can never hit a held, unacknowledged word: ready is low then.
        out_full_d = w_load || (out_full_q && !w_xfer);

        if (w_xfer) begin
            wr_addr_d = w_last_word ? '0 : wr_addr_q + ADDR_W'(1);
            if (w_last_word) begin
                frame_done_d  = 1'b1;
                checksum_d    = sum_q;
                frame_count_d = frame_count_q + 16'd1;
            end
        end

        ready_d = (state_d == ST_RUN) && !((byte_cnt_d == 2'd3) && out_full_d);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            acc_q         <= '0;
            sum_q         <= '0;
            pack_q        <= '0;
            out_full_q    <= 1'b0;
            wr_data_q     <= '0;
            wr_addr_q     <= '0;
            ready_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            checksum_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            acc_q         <= acc_d;
            sum_q         <= sum_d;
            pack_q        <= pack_d;
            out_full_q    <= out_full_d;
            wr_data_q     <= wr_data_d;
            wr_addr_q     <= wr_addr_d;
            ready_q       <= ready_d;
            frame_done_q  <= frame_done_d;
            checksum_q    <= checksum_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign ready_out   = ready_q;
    assign wr_data     = wr_data_q;
    assign wr_addr     = wr_addr_q;
    assign wr_en       = out_full_q;
    assign frame_done  = frame_done_q;
    assign checksum    = checksum_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sink.sv
`default_nettype none
// =====================================================================
// Module   : tb_pixel_frame_sink
// Purpose  : Scoreboard bench for pixel_frame_sink. A small 4x2 instance
//            carries the directed and random streams; a default-size
//            instance carries continuous full frames.
// Revision : 1.0  initial release
// =====================================================================
module tb_pixel_frame_sink;
    localparam int S_NPIX = 8;
    localparam int S_NW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- small instance ----------------
    logic        s_resetn, s_enable, s_valid, s_ready, s_wr_en, s_ack, s_done;
    logic [7:0]  s_pixel, s_wr_addr;
    logic [31:0] s_wr_data;
    logic [15:0] s_checksum, s_count;

    pixel_frame_sink #(.IMG_W(4), .IMG_H(2), .ADDR_W(8)) u_small (
        .clk(clk), .resetn(s_resetn), .enable(s_enable), .pixel_in(s_pixel),
        .valid_in(s_valid), .ready_out(s_ready), .wr_data(s_wr_data),
        .wr_addr(s_wr_addr), .wr_en(s_wr_en), .wr_ack(s_ack),
        .frame_done(s_done), .checksum(s_checksum), .frame_count(s_count)
    );

    // ---------------- default-size instance ----------------
    logic        b_resetn, b_enable, b_valid, b_ready, b_wr_en, b_ack, b_done;
    logic [7:0]  b_pixel, b_wr_addr;
    logic [31:0] b_wr_data;
    logic [15:0] b_checksum, b_count;

    pixel_frame_sink u_big (
        .clk(clk), .resetn(b_resetn), .enable(b_enable), .pixel_in(b_pixel),
        .valid_in(b_valid), .ready_out(b_ready), .wr_data(b_wr_data),
        .wr_addr(b_wr_addr), .wr_en(b_wr_en), .wr_ack(b_ack),
        .frame_done(b_done), .checksum(b_checksum), .frame_count(b_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- reference model and scoreboard (small) ----------------
    typedef struct { logic [31:0] data; logic [7:0] addr; } word_t;
    typedef struct { logic [15:0] sum;  logic [15:0] cnt;  } frame_t;
    word_t  exp_words[$];
    frame_t exp_frames[$];

    int          m_lane = 0, m_npix = 0, m_widx = 0, m_sum = 0;
    logic [31:0] m_word = '0;
    logic [15:0] m_frames = '0;
    logic        prev_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] held_data = '0;
    logic [7:0]  held_addr = '0;

    // Monitor: records accepted pixels into the model and checks every write and frame report
    always @(negedge clk) begin
        word_t  w;
        frame_t f;
        if (!s_resetn) begin
            exp_words.delete();
            exp_frames.delete();
            m_lane = 0; m_npix = 0; m_widx = 0; m_sum = 0; m_word = '0; m_frames = '0;
            prev_stall = 1'b0; prev_done = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_wr_en",   32'(s_wr_en),   32'd1);
                check("hold_wr_data", s_wr_data,      held_data);
                check("hold_wr_addr", 32'(s_wr_addr), 32'(held_addr));
            end
            prev_stall = s_wr_en && !s_ack;
            held_data  = s_wr_data;
            held_addr  = s_wr_addr;

            if (m_lane == 3 && s_wr_en)
                check("ready_low_when_full", 32'(s_ready), 32'd0);

            if (s_done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (exp_frames.size() == 0) begin
                    fail("frame_unexpected", $sformatf("got frame_done checksum 0x%0h, expected none", s_checksum));
                end else begin
                    f = exp_frames.pop_front();
                    check("sb_checksum",    32'(s_checksum), 32'(f.sum));
                    check("sb_frame_count", 32'(s_count),    32'(f.cnt));
                end
            end
            prev_done = s_done;

            if (s_wr_en && s_ack) begin
                if (exp_words.size() == 0) begin
                    fail("word_unexpected", $sformatf("got write 0x%0h @%0d, expected none", s_wr_data, s_wr_addr));
                end else begin
                    w = exp_words.pop_front();
                    check("sb_wr_data", s_wr_data,      w.data);
                    check("sb_wr_addr", 32'(s_wr_addr), 32'(w.addr));
                end
            end

            if (s_valid && s_ready) begin
                m_word[m_lane*8 +: 8] = s_pixel;
                m_lane++;
                m_sum += int'(s_pixel);
                m_npix++;
                if (m_lane == 4) begin
                    w.data = m_word;
                    w.addr = 8'(m_widx % S_NW);
                    exp_words.push_back(w);
                    m_widx++;
                    m_lane = 0;
                end
                if (m_npix == S_NPIX) begin
                    m_frames = m_frames + 16'd1;
                    f.sum = 16'(m_sum);
                    f.cnt = m_frames;
                    exp_frames.push_back(f);
                    m_sum  = 0;
                    m_npix = 0;
                end
            end
        end
    end

    // ---------------- monitor (default size): all-0xFF frames ----------------
    int b_exp_addr = 0, b_done_cnt = 0, b_wraps = 0;
    always @(negedge clk) begin
        if (!b_resetn) begin
            b_exp_addr = 0; b_done_cnt = 0; b_wraps = 0;
        end else begin
            if (b_wr_en && b_ack) begin
                check("big_wr_addr", 32'(b_wr_addr), 32'(b_exp_addr));
                check("big_wr_data", b_wr_data, 32'hFFFF_FFFF);
                if (b_wr_addr == 8'hFF) b_wraps++;
                b_exp_addr = (b_exp_addr + 1) % 256;
            end
            if (b_done) begin
                b_done_cnt++;
                check("big_checksum",    32'(b_checksum), 32'h0000_FC00);
                check("big_frame_count", 32'(b_count),    32'(b_done_cnt));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] stim [0:31];

    task automatic do_reset();
        s_resetn = 1'b0; s_enable = 1'b0; s_valid = 1'b0; s_ack = 1'b0;
        @(posedge clk); #1;
        s_resetn = 1'b1;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ready"},       32'(s_ready),    32'd0);
        check({pfx, "_wr_en"},       32'(s_wr_en),    32'd0);
        check({pfx, "_wr_data"},     s_wr_data,       32'd0);
        check({pfx, "_wr_addr"},     32'(s_wr_addr),  32'd0);
        check({pfx, "_frame_done"},  32'(s_done),     32'd0);
        check({pfx, "_checksum"},    32'(s_checksum), 32'd0);
        check({pfx, "_frame_count"}, 32'(s_count),    32'd0);
    endtask

    // Raise enable from IDLE; ready must still be low this cycle and high the next
    task automatic start_capture();
        s_enable = 1'b1;
        @(negedge clk);
        check("ready_before_run", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_run", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // ack_mode: 0 tied 1, 1 held 0 for 10 cycles after first wr_en, 2 random, 3 held 0
    task automatic run_stream(input int first, input int n, input int gap_pct, input int ack_mode,
                              output int first_drop, output int bubbles);
        int idx = 0, cyc = 0, wen_seen = -1;
        first_drop = -1;
        bubbles    = 0;
        while (idx < n && cyc < 2000) begin
            s_pixel = stim[first + idx];
            s_valid = ($urandom_range(99) >= gap_pct);
            case (ack_mode)
                0:       s_ack = 1'b1;
                1:       s_ack = (wen_seen >= 0) && (cyc - wen_seen >= 10);
                2:       s_ack = 1'($urandom_range(1));
                default: s_ack = 1'b0;
            endcase
            @(negedge clk);
            if (s_wr_en && wen_seen < 0) wen_seen = cyc;
            if (s_valid && !s_ready) begin
                bubbles++;
                if (first_drop < 0) first_drop = idx;
            end
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        if (idx < n) fail("stream_timeout", $sformatf("got %0d accepts, expected %0d", idx, n));
    endtask

    task automatic wait_done(input int budget, input logic [15:0] exp_sum, input logic [15:0] exp_cnt);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (s_done) begin
                seen = 1;
                check("done_checksum", 32'(s_checksum), 32'(exp_sum));
                check("done_count",    32'(s_count),    32'(exp_cnt));
            end
            @(posedge clk); #1;
        end
        if (!seen) fail("frame_done_timeout", $sformatf("got no pulse in %0d cycles, expected one", budget));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int fd, bub, b_acc;
        s_resetn = 1'b0; s_enable = 1'b0; s_valid = 1'b0; s_ack = 1'b0; s_pixel = '0;
        b_resetn = 1'b0; b_enable = 1'b0; b_valid = 1'b0; b_ack = 1'b0; b_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        s_resetn = 1'b1;
        b_resetn = 1'b1;

        // Basic pack and checksum, back-to-back, ack tied high
        for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
        do_reset();
        s_ack = 1'b1;
        start_capture();
        run_stream(0, 8, 0, 0, fd, bub);
        check("basic_no_bubbles", 32'(bub), 32'd0);
        wait_done(20, 16'd36, 16'd1);

        // Backpressure: ack withheld 10 cycles after the first request
        do_reset();
        start_capture();
        run_stream(0, 8, 0, 1, fd, bub);
        check("bp_drop_after_accepts", 32'(fd), 32'd7);
        s_ack = 1'b1;
        wait_done(30, 16'd36, 16'd1);

        // Enable drop after pixel 3: frame completes, sink drains then idles
        do_reset();
        s_ack = 1'b1;
        start_capture();
        run_stream(0, 3, 0, 0, fd, bub);
        s_enable = 1'b0;
        run_stream(3, 5, 0, 0, fd, bub);
        wait_done(20, 16'd36, 16'd1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            @(negedge clk);
            check("ready_after_drain", 32'(s_ready), 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("count_after_drain", 32'(s_count), 32'd1);

        // Reset while a word is pending and two bytes are packed
        do_reset();
        start_capture();
        run_stream(0, 6, 0, 3, fd, bub);
        @(negedge clk);
        check("pre_reset_wr_en", 32'(s_wr_en), 32'd1);
        @(posedge clk); #1;
        s_resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        s_resetn = 1'b1;
        for (int i = 0; i < 8; i++) stim[8 + i] = 8'(100 + i);
        s_ack = 1'b1;
        start_capture();
        run_stream(8, 8, 0, 0, fd, bub);
        wait_done(20, 16'd828, 16'd1);

        // Random valid gaps against the same 1..8 stream
        do_reset();
        s_ack = 1'b1;
        start_capture();
        run_stream(0, 8, 40, 0, fd, bub);
        check("gaps_no_bubbles", 32'(bub), 32'd0);
        wait_done(20, 16'd36, 16'd1);

        // Three frames of random pixels with random gaps and random ack
        for (int i = 0; i < 24; i++) stim[i] = 8'($urandom_range(255));
        do_reset();
        start_capture();
        run_stream(0, 24, 30, 2, fd, bub);
        s_ack = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("random_frame_count", 32'(s_count), 32'd3);

        // Continuous full-size frames of 0xFF on the default instance
        b_acc    = 0;
        b_enable = 1'b1; b_valid = 1'b1; b_ack = 1'b1; b_pixel = 8'hFF;
        for (int c = 0; c < 4000 && b_done_cnt < 3; c++) begin
            @(negedge clk);
            if (b_valid && b_ready) b_acc++;
            @(posedge clk); #1;
            if (b_acc >= 2100) b_enable = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b_valid && b_ready) b_acc++;
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        check("big_accepts",   32'(b_acc),      32'd3072);
        check("big_frames",    32'(b_done_cnt), 32'd3);
        check("big_addr_wraps", 32'(b_wraps),   32'd3);
        check("big_final_addr", 32'(b_wr_addr), 32'd0);

        check("sb_words_drained",  32'(exp_words.size()),  32'd0);
        check("sb_frames_drained", 32'(exp_frames.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_frame_sink.md
# pixel_frame_sink

Terminal consumer for the processed pixel stream leaving the processor stage (8-bit pixel, valid/ready). It sits in the `clk` domain downstream of the processor's output port and replaces bench-driven `ready`. The block:
- accepts pixels under an enable-controlled state machine;
- packs four pixels into one 32-bit word and writes words to a frame buffer over a held-request/ack port;
- tracks frame boundaries and reports a per-frame checksum and a frame count.

## Interface
- `IMG_W`, default 32: pixels per line.
- `IMG_H`, default 32: lines per frame. `IMG_W*IMG_H` must be a multiple of 4.
- `ADDR_W`, default 8: word-address width. Must satisfy `2^ADDR_W >= IMG_W*IMG_H/4`.
- `clk` input 1: clock, all logic on the rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `enable` input 1: capture enable, level-sensitive.
- `pixel_in` input 8: pixel from the processor.
- `valid_in` input 1: `pixel_in` valid.
- `ready_out` output 1: sink can accept a pixel.
- `wr_data` output 32: packed word; first pixel of the group in [7:0], fourth in [31:24].
- `wr_addr` output ADDR_W: word address within the frame buffer.
- `wr_en` output 1: write request, held until acknowledged.
- `wr_ack` input 1: write accepted on this edge.
- `frame_done` output 1: one-cycle pulse when a frame is fully written.
- `checksum` output 16: sum of all pixels of the last completed frame, mod 2^16.
- `frame_count` output 16: completed frames, wraps 0xFFFF→0.

## Operation
- **States**
  - IDLE: `ready_out`=0. Go to RUN when `enable`=1.
  - RUN: `ready_out` as per the packing rule below. On acceptance of the last pixel of a frame (`pix_cnt`==`IMG_W*IMG_H`-1): if `enable`=0, go to DRAIN, else stay in RUN.
  - DRAIN: `ready_out`=0. Go to IDLE once the output word register is empty.
- `enable` falling mid-frame does not stop capture. The current frame always completes.
- **Accept:** a pixel is accepted on an edge where `valid_in` && `ready_out`. On accept:
  - the pixel goes into pack byte lane `byte_cnt`;
  - `byte_cnt` increments mod 4;
  - `pix_cnt` increments and wraps to 0 after the last pixel of the frame;
  - the pixel is added to the 16-bit checksum accumulator.
- **Packing:** on the 4th byte accept, the completed word loads into the output register (`wr_data`, `wr_en`=1). `ready_out` in RUN = !(`byte_cnt`==3 && `out_full`). It is derived from registers only, never combinationally from `wr_ack` or `valid_in`.
- **Write port:**
  - While `wr_en`=1, `wr_data` and `wr_addr` are stable.
  - A transfer occurs on an edge where `wr_en` && `wr_ack`.
  - After a transfer, `wr_addr` increments. It wraps to 0 after word `IMG_W*IMG_H/4`-1.
  - `wr_ack` while `wr_en`=0 is ignored.
- **Simultaneous transfer and load:** a transfer and a new word load on the same edge is legal. The register takes the new word, `wr_en` stays 1, and `wr_addr` advances.
- **Frame end:** the cycle after the transfer of the frame's last word:
  - `frame_done`=1 for exactly one cycle;
  - `checksum` ← accumulator (including the final pixels);
  - the accumulator clears, and pixels accepted in the same cycle start the new sum;
  - `frame_count` increments.
- **Reset:** `resetn`=0 at any edge, including mid-frame or mid-write, forces:
  - state IDLE;
  - all counters, accumulator and pack register to 0;
  - `ready_out`=0, `wr_en`=0, `wr_data`=0, `wr_addr`=0, `frame_done`=0, `checksum`=0, `frame_count`=0.
  - A partially packed word is discarded.

## Timing
- `ready_out` rises the cycle after the edge on which RUN is entered. It is never high in IDLE or DRAIN.
- Pixel-to-write latency: `wr_en` rises the cycle after the 4th pixel of a group is accepted.
- With `wr_ack` tied 1, throughput is 1 pixel/cycle sustained, with no `ready_out` bubbles.
- With `wr_ack` withheld, `ready_out` falls only when `byte_cnt`==3 and the word register is full. After the ack edge, `ready_out` returns the next cycle (one bubble).
- Final-word ack → `frame_done` pulse latency: 1 cycle.

## Test plan
- **Basic pack and checksum:** `IMG_W`=4, `IMG_H`=2, `wr_ack`=1, `enable`=1, pixels 1..8 back-to-back.
  - Writes 0x04030201 @0 and 0x08070605 @1.
  - `frame_done` pulse; `checksum`=36; `frame_count`=1; no `ready_out` low cycles after start.
- **Backpressure:** same stream, `wr_ack` held 0 for 10 cycles after the first `wr_en`.
  - `ready_out` drops after 7 accepts.
  - `wr_data` and `wr_addr` are stable through the stall; no pixel is lost or duplicated; the final words match the basic case.
- **Enable drop mid-frame:** deassert `enable` after pixel 3 of frame 1.
  - Frame 1 completes; DRAIN, then IDLE; `ready_out`=0 afterwards; `frame_count`=1.
- **Continuous frames:** 3 frames of value 0xFF, default size.
  - `wr_addr` wraps 255→0.
  - `checksum` = (1024×255) mod 65536 = 0xFC00 per frame; `frame_count`=3; three `frame_done` pulses.
- **Reset mid-write:** assert `resetn`=0 while `wr_en`=1 and `byte_cnt`=2.
  - The next cycle shows all outputs 0.
  - After release and `enable`, the new frame writes from address 0 with a fresh checksum.
- **Invalid gaps:** random `valid_in` deassertion.
  - Words and checksum are identical to the back-to-back case; nothing is accepted while `valid_in`=0.
